// File: rtl/scalar_mult_sequencer_pkg.sv
// Shared command codes and FSM state encoding for the scalar-multiplication sequencer.
package scalar_mult_sequencer_pkg;

  localparam logic [1:0] CMD_NONE   = 2'b00;
  localparam logic [1:0] CMD_DOUBLE = 2'b01;
  localparam logic [1:0] CMD_ADD    = 2'b10;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SCAN      = 4'd1,
    ISSUE_DBL = 4'd2,
    WAIT_DBL  = 4'd3,
    ISSUE_ADD = 4'd4,
    WAIT_ADD  = 4'd5,
    NEXT      = 4'd6,
    DONE      = 4'd7,
    ERR       = 4'd8
  } state_t;

endpackage

// File: rtl/scalar_mult_sequencer_op_watchdog.sv
// Per-operation watchdog: reloads on clear, counts down while enabled, flags the last allowed wait cycle.
module op_watchdog
  import scalar_mult_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 1048575,
  parameter int CNTW    = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNTW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= CNTW'(TIMEOUT - 1);
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // Zero means this wait cycle is the TIMEOUT-th one since the command.
  assign expired = (count_reg == '0);

endmodule

// File: rtl/scalar_mult_sequencer.sv
// Left-to-right double-and-add sequencer driving the point add/double command interface.
module scalar_mult_sequencer
  import scalar_mult_sequencer_pkg::*;
#(
  parameter int K       = 256,
  parameter int IDXW    = 10,
  parameter int TIMEOUT = 1048575,
  parameter int CNTW    = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [K-1:0]    scalar,
  input  logic [IDXW-1:0] scalar_len,
  input  logic            interupt_point_double,
  input  logic            interupt_point_addition,
  output logic [1:0]      command,
  output logic            busy,
  output logic            done,
  output logic            zero_result,
  output logic            timeout_err,
  output logic [IDXW-1:0] bit_index,
  output logic [IDXW-1:0] dbl_count,
  output logic [IDXW-1:0] add_count
);

  localparam int SIW = $clog2(K);

  state_t          state_reg;
  logic [K-1:0]    sreg_reg;
  logic [1:0]      command_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            zero_reg;
  logic            terr_reg;
  logic [IDXW-1:0] index_reg;
  logic [IDXW-1:0] dbl_reg;
  logic [IDXW-1:0] add_reg;

  logic [IDXW-1:0] effl;
  logic            cur_bit;
  logic            wd_clear;
  logic            wd_enable;
  logic            wd_expired;

  assign effl      = (scalar_len > IDXW'(K)) ? IDXW'(K) : scalar_len;
  // index never exceeds K-1, so the low SIW bits address the scalar fully
  assign cur_bit   = sreg_reg[index_reg[SIW-1:0]];
  assign wd_clear  = (state_reg == ISSUE_DBL) || (state_reg == ISSUE_ADD);
  assign wd_enable = (state_reg == WAIT_DBL) || (state_reg == WAIT_ADD);

  op_watchdog #(
    .TIMEOUT(TIMEOUT),
    .CNTW   (CNTW)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sreg_reg    <= '0;
      command_reg <= CMD_NONE;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      zero_reg    <= 1'b0;
      terr_reg    <= 1'b0;
      index_reg   <= '0;
      dbl_reg     <= '0;
      add_reg     <= '0;
    end else begin
      done_reg    <= 1'b0;
      command_reg <= CMD_NONE;
      case (state_reg)
        IDLE: begin
          if (start) begin
            sreg_reg <= scalar;
            busy_reg <= 1'b1;
            dbl_reg  <= '0;
            add_reg  <= '0;
            zero_reg <= 1'b0;
            terr_reg <= 1'b0;
            if (effl == '0) begin
              index_reg <= '0;
              zero_reg  <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              index_reg <= effl - 1'b1;
              state_reg <= SCAN;
            end
          end
        end
        SCAN: begin
          if (cur_bit && (index_reg == '0)) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else if (cur_bit) begin
            index_reg   <= index_reg - 1'b1;
            command_reg <= CMD_DOUBLE;
            dbl_reg     <= dbl_reg + 1'b1;
            state_reg   <= ISSUE_DBL;
          end else if (index_reg == '0) begin
            zero_reg  <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            index_reg <= index_reg - 1'b1;
          end
        end
        ISSUE_DBL: state_reg <= WAIT_DBL;
        WAIT_DBL: begin
          // a matching pulse wins over a simultaneous watchdog expiry
          if (interupt_point_double) begin
            if (cur_bit) begin
              command_reg <= CMD_ADD;
              add_reg     <= add_reg + 1'b1;
              state_reg   <= ISSUE_ADD;
            end else begin
              state_reg <= NEXT;
            end
          end else if (wd_expired) begin
            terr_reg  <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= ERR;
          end
        end
        ISSUE_ADD: state_reg <= WAIT_ADD;
        WAIT_ADD: begin
          if (interupt_point_addition) begin
            state_reg <= NEXT;
          end else if (wd_expired) begin
            terr_reg  <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= ERR;
          end
        end
        NEXT: begin
          if (index_reg == '0) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            index_reg   <= index_reg - 1'b1;
            command_reg <= CMD_DOUBLE;
            dbl_reg     <= dbl_reg + 1'b1;
            state_reg   <= ISSUE_DBL;
          end
        end
        DONE, ERR: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign command     = command_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign zero_result = zero_reg;
  assign timeout_err = terr_reg;
  assign bit_index   = index_reg;
  assign dbl_count   = dbl_reg;
  assign add_count   = add_reg;

endmodule
